mem_port_arbiter: RTL and testbench

Sequential arbiter that shares one single-ported, variable-latency RAM between the pipeline's instruction-fetch (IF) stage and data-memory (MEM) stage. It serialises requests, drives the RAM-side handshake, returns read data to the winning port, and generates per-port stall signals. The hazard logic combines these stalls into the PC-stop and IF/ID-hold controls. A watchdog aborts RAM accesses that are never acknowledged.

---
 rtl/cpu_mem_pkg.sv | 20 ++
 rtl/mem_watchdog.sv | 31 +++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared memory-path definitions: arbiter state encoding and default bus widths.
package cpu_mem_pkg;

  localparam int unsigned CPU_ADDR_W = 16;
  localparam int unsigned CPU_DATA_W = 16;
  localparam int unsigned WD_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Saturating increment used by the fetch-starvation counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] val, input logic [7:0] lim);
    return (val >= lim) ? lim : val + 8'd1;
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// RAM access watchdog: loadable up-counter, flags expiry at TIMEOUT-1.
module mem_watchdog
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_clear,
  input  logic                i_load,
  input  logic [WD_CNT_W-1:0] i_load_val,
  input  logic                i_en,
  output logic                o_expired
);

  logic [WD_CNT_W-1:0] r_cnt;

  // Counter: clear wins over load, load wins over count.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == WD_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency RAM between the fetch and data ports.
// Fixed-priority toward data, with a starvation limit that forces a fetch.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = CPU_ADDR_W,
  parameter int DATA_W       = CPU_DATA_W,
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 16
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  output logic              o_if_stall,
  input  logic              i_mem_req,
  input  logic              i_mem_we,
  input  logic              i_mem_byte,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_valid,
  output logic              o_mem_stall,
  output logic              o_ram_req,
  output logic              o_ram_we,
  output logic              o_ram_byte,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata,
  input  logic              i_ram_ack,
  output logic              o_bus_error
);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic        w_grant_if;
  logic        w_grant_mem;
  logic        w_finish;
  logic        w_abort;
  logic        w_wd_expired;
  logic        w_busy;
  logic        r_owner_mem;
  logic [7:0]  r_starve_cnt;
  logic [DATA_W-1:0] w_ret_data;

  assign w_busy     = (r_state == ST_FETCH) || (r_state == ST_DATA);
  assign w_ret_data = w_abort ? '0 : i_ram_rdata;

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_clear    (r_state == ST_DONE),
    .i_load     (w_grant_if || w_grant_mem),
    .i_load_val ('0),
    .i_en       (w_busy),
    .o_expired  (w_wd_expired)
  );

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: arbitration in IDLE, completion/abort while busy, one turnaround cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    w_finish    = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_mem_req && (!i_if_req || (r_starve_cnt != 8'(STARVE_LIMIT)))) begin
          w_grant_mem = 1'b1;
          w_state_nxt = ST_DATA;
        end else if (i_if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (i_ram_ack) begin
          w_finish = 1'b1;
        end else if (w_wd_expired) begin
          w_finish = 1'b1;
          w_abort  = 1'b1;
        end
        if (w_finish) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered RAM command and per-port completion outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ram_req   <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_byte  <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      r_owner_mem <= 1'b0;
      o_if_rdata  <= '0;
      o_if_valid  <= 1'b0;
      o_mem_rdata <= '0;
      o_mem_valid <= 1'b0;
      o_bus_error <= 1'b0;
    end else begin
      o_if_valid  <= 1'b0;
      o_mem_valid <= 1'b0;
      o_bus_error <= 1'b0;
      if (w_grant_if || w_grant_mem) begin
        o_ram_req   <= 1'b1;
        o_ram_we    <= w_grant_mem && i_mem_we;
        o_ram_byte  <= w_grant_mem && i_mem_byte;
        o_ram_addr  <= w_grant_mem ? i_mem_addr : i_if_addr;
        o_ram_wdata <= w_grant_mem ? i_mem_wdata : '0;
        r_owner_mem <= w_grant_mem;
      end
      if (w_finish) begin
        o_ram_req   <= 1'b0;
        o_bus_error <= w_abort;
        if (r_owner_mem) begin
          o_mem_rdata <= w_ret_data;
          o_mem_valid <= 1'b1;
        end else begin
          o_if_rdata <= w_ret_data;
          o_if_valid <= 1'b1;
        end
      end
    end
  end

  // Starvation counter: counts data grants taken while a fetch waits.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
    end else if (w_grant_if) begin
      r_starve_cnt <= '0;
    end else if (w_grant_mem && i_if_req) begin
      r_starve_cnt <= sat_inc(r_starve_cnt, 8'(STARVE_LIMIT));
    end
  end

  assign o_if_stall  = i_if_req && !o_if_valid;
  assign o_mem_stall = i_mem_req && !o_mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_valid, if_stall;
  logic        mem_req, mem_we, mem_byte;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_valid, mem_stall;
  logic        ram_req, ram_we, ram_byte;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;
  logic        ram_ack;
  logic        bus_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(3), .TIMEOUT(16)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_rdata  (if_rdata),
    .o_if_valid  (if_valid),
    .o_if_stall  (if_stall),
    .i_mem_req   (mem_req),
    .i_mem_we    (mem_we),
    .i_mem_byte  (mem_byte),
    .i_mem_addr  (mem_addr),
    .i_mem_wdata (mem_wdata),
    .o_mem_rdata (mem_rdata),
    .o_mem_valid (mem_valid),
    .o_mem_stall (mem_stall),
    .o_ram_req   (ram_req),
    .o_ram_we    (ram_we),
    .o_ram_byte  (ram_byte),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata),
    .i_ram_ack   (ram_ack),
    .o_bus_error (bus_error)
  );

  typedef struct {
    logic        if_req, mem_req, mem_we, mem_byte;
    logic [15:0] if_addr, mem_addr, mem_wdata;
    int          wait_cyc;
    logic        ack, drop;
    logic [15:0] ram_data;
    logic        exp_we, exp_byte;
    logic [15:0] exp_addr, exp_wdata;
    logic        exp_if_valid, exp_mem_valid;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_byte = 0;
    mem_addr = '0; mem_wdata = '0; ram_rdata = '0; ram_ack = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".ram_req"},   32'(ram_req),   0);
    chk({tag, ".ram_we"},    32'(ram_we),    0);
    chk({tag, ".ram_byte"},  32'(ram_byte),  0);
    chk({tag, ".ram_addr"},  32'(ram_addr),  0);
    chk({tag, ".ram_wdata"}, 32'(ram_wdata), 0);
    chk({tag, ".if_valid"},  32'(if_valid),  0);
    chk({tag, ".mem_valid"}, 32'(mem_valid), 0);
    chk({tag, ".if_rdata"},  32'(if_rdata),  0);
    chk({tag, ".mem_rdata"}, 32'(mem_rdata), 0);
    chk({tag, ".bus_error"}, 32'(bus_error), 0);
  endtask

  initial begin
    vecs[0] = '{1,0,0,0, 16'h0004,16'h0000,16'h0000, 1, 1,0,16'h1234, 0,0,16'h0004,16'h0000, 1,0,16'h1234,0};
    vecs[1] = '{0,1,0,0, 16'h0000,16'h0010,16'h0000, 3, 1,0,16'h00AB, 0,0,16'h0010,16'h0000, 0,1,16'h00AB,0};
    vecs[2] = '{0,1,1,1, 16'h0000,16'h0021,16'h00FF, 4, 1,0,16'hBEEF, 1,1,16'h0021,16'h00FF, 0,1,16'hBEEF,0};
    vecs[3] = '{1,0,1,1, 16'h0100,16'h0222,16'h3333, 2, 1,0,16'hCAFE, 0,0,16'h0100,16'h0000, 1,0,16'hCAFE,0};
    vecs[4] = '{0,1,0,0, 16'h0000,16'h0030,16'h0000, 16,0,0,16'h5555, 0,0,16'h0030,16'h0000, 0,1,16'h0000,1};
    vecs[5] = '{1,0,0,0, 16'h0200,16'h0000,16'h0000, 2, 1,1,16'h7777, 0,0,16'h0200,16'h0000, 1,0,16'h7777,0};
    vecs[6] = '{0,1,1,0, 16'h0000,16'h0400,16'hA5A5, 1, 1,1,16'h0F0F, 1,0,16'h0400,16'hA5A5, 0,1,16'h0F0F,0};

    // Reset state
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    check_all_zero("reset");

    // Ack while idle must be ignored
    ram_ack = 1; ram_rdata = 16'hDEAD;
    tick();
    ram_ack = 0;
    tick();
    chk("idle_ack.if_valid",  32'(if_valid),  0);
    chk("idle_ack.mem_valid", 32'(mem_valid), 0);
    chk("idle_ack.ram_req",   32'(ram_req),   0);

    // Simultaneous requests: data first, fetch after turnaround
    if_req = 1; if_addr = 16'h0040; mem_req = 1; mem_we = 0; mem_addr = 16'h0010; ram_rdata = 16'h00AB;
    tick();
    chk("sim.first_addr", 32'(ram_addr), 32'h0010);
    chk("sim.first_we",   32'(ram_we),   0);
    chk("sim.first_req",  32'(ram_req),  1);
    ram_ack = 1;
    tick();
    ram_ack = 0;
    chk("sim.mem_valid", 32'(mem_valid), 1);
    chk("sim.mem_rdata", 32'(mem_rdata), 32'h00AB);
    chk("sim.if_valid",  32'(if_valid),  0);
    chk("sim.if_stall",  32'(if_stall),  1);
    mem_req = 0;
    tick();
    chk("sim.idle_req",       32'(ram_req),   0);
    chk("sim.mem_valid_drop", 32'(mem_valid), 0);
    ram_rdata = 16'h4321;
    tick();
    chk("sim.fetch_req",  32'(ram_req),  1);
    chk("sim.fetch_addr", 32'(ram_addr), 32'h0040);
    ram_ack = 1;
    tick();
    ram_ack = 0;
    chk("sim.if_valid2", 32'(if_valid), 1);
    chk("sim.if_rdata",  32'(if_rdata), 32'h4321);
    if_req = 0;
    tick();

    // Starvation: D D D F repeated twice with both ports requesting
    if_req = 1; if_addr = 16'h0060; mem_req = 1; mem_addr = 16'h0050;
    for (int k = 0; k < 8; k++) begin
      logic exp_fetch;
      exp_fetch = ((k % 4) == 3);
      tick();
      chk($sformatf("starve%0d.addr", k), 32'(ram_addr), exp_fetch ? 32'h0060 : 32'h0050);
      ram_rdata = 16'(k); ram_ack = 1;
      tick();
      ram_ack = 0;
      chk($sformatf("starve%0d.if_valid", k),  32'(if_valid),  32'(exp_fetch));
      chk($sformatf("starve%0d.mem_valid", k), 32'(mem_valid), 32'(!exp_fetch));
      tick();
    end
    if_req = 0; mem_req = 0;
    tick();

    // Reset in the middle of a data access
    mem_req = 1; mem_addr = 16'h0070;
    tick();
    chk("rstmid.req_before", 32'(ram_req), 1);
    mem_req = 0;
    tick();
    rst = 1; ram_ack = 1; ram_rdata = 16'h9999;
    tick();
    chk("rstmid.ram_req",   32'(ram_req),   0);
    chk("rstmid.ram_addr",  32'(ram_addr),  0);
    chk("rstmid.mem_valid", 32'(mem_valid), 0);
    chk("rstmid.mem_rdata", 32'(mem_rdata), 0);
    chk("rstmid.bus_error", 32'(bus_error), 0);
    rst = 0; ram_ack = 0;
    tick();
    chk("rstmid.mem_valid_after", 32'(mem_valid), 0);
    chk("rstmid.ram_req_after",   32'(ram_req),   0);

    // Table-driven single transactions from IDLE
    foreach (vecs[n]) begin
      vec_t v;
      v = vecs[n];
      if_req = v.if_req; if_addr = v.if_addr;
      mem_req = v.mem_req; mem_we = v.mem_we; mem_byte = v.mem_byte;
      mem_addr = v.mem_addr; mem_wdata = v.mem_wdata; ram_rdata = v.ram_data;
      tick();
      if (v.drop) begin
        if_req = 0; mem_req = 0;
      end
      for (int i = 0; i < v.wait_cyc; i++) begin
        chk($sformatf("v%0d.c%0d.ram_req", n, i), 32'(ram_req), 1);
        chk($sformatf("v%0d.c%0d.ram_addr", n, i), 32'(ram_addr), 32'(v.exp_addr));
        if (i == 0) begin
          chk($sformatf("v%0d.ram_we", n),    32'(ram_we),    32'(v.exp_we));
          chk($sformatf("v%0d.ram_byte", n),  32'(ram_byte),  32'(v.exp_byte));
          chk($sformatf("v%0d.ram_wdata", n), 32'(ram_wdata), 32'(v.exp_wdata));
          chk($sformatf("v%0d.early_valid", n), 32'({if_valid, mem_valid}), 0);
        end
        if (i == v.wait_cyc - 1) begin
          chk($sformatf("v%0d.ram_we_last", n),    32'(ram_we),    32'(v.exp_we));
          chk($sformatf("v%0d.ram_wdata_last", n), 32'(ram_wdata), 32'(v.exp_wdata));
          if (v.ack) ram_ack = 1;
        end
        tick();
        ram_ack = 0;
      end
      chk($sformatf("v%0d.done_ram_req", n), 32'(ram_req),   0);
      chk($sformatf("v%0d.if_valid", n),     32'(if_valid),  32'(v.exp_if_valid));
      chk($sformatf("v%0d.mem_valid", n),    32'(mem_valid), 32'(v.exp_mem_valid));
      chk($sformatf("v%0d.bus_error", n),    32'(bus_error), 32'(v.exp_err));
      if (v.exp_if_valid)
        chk($sformatf("v%0d.if_rdata", n), 32'(if_rdata), 32'(v.exp_rdata));
      else
        chk($sformatf("v%0d.mem_rdata", n), 32'(mem_rdata), 32'(v.exp_rdata));
      chk($sformatf("v%0d.if_stall", n),  32'(if_stall),  32'(if_req && !v.exp_if_valid));
      chk($sformatf("v%0d.mem_stall", n), 32'(mem_stall), 32'(mem_req && !v.exp_mem_valid));
      if_req = 0; mem_req = 0;
      tick();
      chk($sformatf("v%0d.post_valid", n), 32'({if_valid, mem_valid, bus_error}), 0);
      chk($sformatf("v%0d.post_req", n),   32'(ram_req), 0);
      idle_inputs();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
